float_div: RTL and testbench

FLOAT_DIV -- requirements
Module: float_div

---
 rtl/float16_pkg.sv | 14 +
 rtl/float_div_core.sv | 57 +++++
 rtl/float_div.sv | 138 +++++++++++++
 tb/tb_float_div.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/float16_pkg.sv
// Shared widths, constants and FSM state type for the half-precision divider.
package float16_pkg;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 10;
  localparam int FRAC_W   = MANT_W + 1;
  localparam int REM_W    = FRAC_W + 1;
  localparam int EXP_BIAS = 15;
  localparam int QUO_BITS = 12;
  localparam int CNT_W    = 4;
  localparam int EXPI_W   = 7;
  localparam logic [14:0] INF_MAG = 15'h7C00;

  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_NORM, ST_DONE} state_e;
endpackage

// File: rtl/float_div_core.sv
// 12-bit restoring mantissa divider: one quotient bit per step, MSB first.
module float_div_core
  import float16_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                step_i,
  input  logic [FRAC_W-1:0]   frac_a_i,
  input  logic [FRAC_W-1:0]   frac_b_i,
  output logic [QUO_BITS-1:0] quo_o,
  output logic                last_o
);
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [FRAC_W-1:0]   frac_b_q, frac_b_d;
  logic [QUO_BITS-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REM_W-1:0]    diff;
  logic                q_bit;

  always_comb begin
    rem_d    = rem_q;
    frac_b_d = frac_b_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    q_bit    = (rem_q >= {1'b0, frac_b_q});
    diff     = q_bit ? (rem_q - {1'b0, frac_b_q}) : rem_q;
    if (load_i) begin
      rem_d    = {1'b0, frac_a_i};
      frac_b_d = frac_b_i;
      quo_d    = '0;
      cnt_d    = CNT_W'(QUO_BITS - 1);
    end else if (step_i) begin
      // After a subtract the remainder is below fracB, so the shift cannot lose its MSB.
      rem_d = {diff[REM_W-2:0], 1'b0};
      quo_d = {quo_q[QUO_BITS-2:0], q_bit};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      frac_b_q <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rem_q    <= rem_d;
      frac_b_q <= frac_b_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign quo_o  = quo_q;
  assign last_o = (cnt_q == '0);
endmodule

// File: rtl/float_div.sv
// Half-precision divider top: operand capture, FSM, normalisation and special cases.
// Define FLOAT_DIV_OVF_SAT_EN to saturate exponent overflow to signed infinity (else zero).
module float_div
  import float16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] floatA,
  input  logic [15:0] floatB,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic        divZero
);
  localparam logic signed [EXPI_W-1:0] BIAS_S    = EXPI_W'(EXP_BIAS);
  localparam logic signed [EXPI_W-1:0] ONE_S     = EXPI_W'(1);
  localparam logic signed [EXPI_W-1:0] EXP_MAX_S = EXPI_W'((1 << EXP_W) - 1);

  state_e                     state_q, state_d;
  logic                       sign_q, sign_d;
  logic signed [EXPI_W-1:0]   exp_q, exp_d;
  logic                       a_zero_q, a_zero_d;
  logic                       b_zero_q, b_zero_d;
  logic [15:0]                quotient_q, quotient_d;
  logic                       div_zero_q, div_zero_d;

  logic                       load, step;
  logic [QUO_BITS-1:0]        core_quo;
  logic                       core_last;
  logic signed [EXPI_W-1:0]   exp_a, exp_b, exp_norm;
  logic [MANT_W-1:0]          mant_norm;
  logic [15:0]                result;
  logic                       result_dz;

  assign exp_a = {{(EXPI_W-EXP_W){1'b0}}, floatA[MANT_W +: EXP_W]};
  assign exp_b = {{(EXPI_W-EXP_W){1'b0}}, floatB[MANT_W +: EXP_W]};

  float_div_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
    .frac_a_i ({1'b1, floatA[MANT_W-1:0]}),
    .frac_b_i ({1'b1, floatB[MANT_W-1:0]}),
    .quo_o    (core_quo),
    .last_o   (core_last)
  );

  always_comb begin
    if (core_quo[QUO_BITS-1]) begin
      exp_norm  = exp_q;
      mant_norm = core_quo[QUO_BITS-2:1];
    end else begin
      exp_norm  = exp_q - ONE_S;
      mant_norm = core_quo[MANT_W-1:0];
    end
    result    = '0;
    result_dz = 1'b0;
    // Zero divisor wins over a zero dividend.
    if (b_zero_q) begin
      result    = {sign_q, INF_MAG};
      result_dz = 1'b1;
    end else if (a_zero_q) begin
      result = '0;
    end else if (exp_norm <= 0) begin
      result = '0;
    end else if (exp_norm >= EXP_MAX_S) begin
`ifdef FLOAT_DIV_OVF_SAT_EN
      result = {sign_q, INF_MAG};
`else
      result = '0;
`endif
    end else begin
      result = {sign_q, exp_norm[EXP_W-1:0], mant_norm};
    end
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    sign_d     = sign_q;
    exp_d      = exp_q;
    a_zero_d   = a_zero_q;
    b_zero_d   = b_zero_q;
    quotient_d = quotient_q;
    div_zero_d = div_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          sign_d   = floatA[15] ^ floatB[15];
          exp_d    = exp_a - exp_b + BIAS_S;
          a_zero_d = (floatA[MANT_W +: EXP_W] == '0);
          b_zero_d = (floatB[MANT_W +: EXP_W] == '0);
          state_d  = ST_DIV;
        end
      end
      ST_DIV: begin
        step = 1'b1;
        if (core_last) state_d = ST_NORM;
      end
      ST_NORM: begin
        quotient_d = result;
        div_zero_d = result_dz;
        state_d    = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      a_zero_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      quotient_q <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      a_zero_q   <= a_zero_d;
      b_zero_q   <= b_zero_d;
      quotient_q <= quotient_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign quotient = quotient_q;
  assign divZero  = div_zero_q;
endmodule

// File: tb/tb_float_div.sv
// Self-checking bench for float_div: vector table, scoreboard, handshake/reset sequences.
module tb_float_div;
  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] floatA, floatB;
  logic        busy, done, divZero;
  logic [15:0] quotient;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        dz;
  } vec_t;

  typedef struct packed {
    logic [15:0] q;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  float_div dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .floatA   (floatA),
    .floatB   (floatB),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .divZero  (divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FLOAT_DIV_OVF_SAT_EN
  localparam bit OVF_SAT = 1'b1;
`else
  localparam bit OVF_SAT = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Arithmetic reference: quotient by integer division of the scaled significands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    int   ea, eb, fa, fb, qv, e, mant;
    logic s;
    exp_t r;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    s  = a[15] ^ b[15];
    r.q  = 16'h0000;
    r.dz = 1'b0;
    if (eb == 0) begin
      r.q  = {s, 15'h7C00};
      r.dz = 1'b1;
      return r;
    end
    if (ea == 0) return r;
    fa = 1024 + int'(a[9:0]);
    fb = 1024 + int'(b[9:0]);
    qv = (fa * 2048) / fb;
    e  = ea - eb + 15;
    if (qv >= 2048) mant = (qv / 2) % 1024;
    else begin
      mant = qv % 1024;
      e    = e - 1;
    end
    if (e <= 0) r.q = 16'h0000;
    else if (e >= 31) r.q = OVF_SAT ? {s, 15'h7C00} : 16'h0000;
    else r.q = {s, 5'(e), 10'(mant)};
    return r;
  endfunction

  // One full operation; dbl=1 pulses a second start with other operands before E5.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input exp_t ex, input bit dbl, input int tag);
    int   n;
    bit   got;
    exp_t e;
    sb.push_back(ex);
    @(negedge clk);
    rst    = 1'b0;
    floatA = a;
    floatB = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    floatA = 16'h0000;
    floatB = 16'h0000;
    chk($sformatf("busy_after_start[%0d]", tag), {31'd0, busy}, 32'd1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 30) begin
      if (dbl && n == 4) begin
        floatA = 16'h3C00;
        floatB = 16'h4200;
        start  = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      chk($sformatf("done_timeout[%0d]", tag), 32'd0, 32'd1);
    end else begin
      chk($sformatf("latency[%0d]", tag), n, 32'd13);
      chk($sformatf("quotient[%0d]", tag), {16'd0, quotient}, {16'd0, e.q});
      chk($sformatf("divZero[%0d]", tag), {31'd0, divZero}, {31'd0, e.dz});
      @(posedge clk); #1;
      chk($sformatf("done_pulse[%0d]", tag), {31'd0, done}, 32'd0);
      chk($sformatf("idle_busy[%0d]", tag), {31'd0, busy}, 32'd0);
      chk($sformatf("quotient_hold[%0d]", tag), {16'd0, quotient}, {16'd0, e.q});
    end
  endtask

  initial begin
    vec_t tbl[9];
    exp_t ex;
    int   dcount;
    logic [15:0] ra, rb;

    tbl[0] = '{16'h3C00, 16'h3C00, 16'h3C00, 1'b0};
    tbl[1] = '{16'h4200, 16'h4000, 16'h3E00, 1'b0};
    tbl[2] = '{16'hBC00, 16'h4200, 16'hB555, 1'b0};
    tbl[3] = '{16'h4000, 16'h0000, 16'h7C00, 1'b1};
    tbl[4] = '{16'hC000, 16'h0000, 16'hFC00, 1'b1};
    tbl[5] = '{16'h0000, 16'h4000, 16'h0000, 1'b0};
    tbl[6] = '{16'h7800, 16'h0400, (OVF_SAT ? 16'h7C00 : 16'h0000), 1'b0};
    tbl[7] = '{16'h0400, 16'h7800, 16'h0000, 1'b0};
    tbl[8] = '{16'h0000, 16'h0000, 16'h7C00, 1'b1};

    rst    = 1'b1;
    start  = 1'b0;
    floatA = 16'h0000;
    floatB = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_divZero", {31'd0, divZero}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      ex.q  = tbl[i].q;
      ex.dz = tbl[i].dz;
      do_op(tbl[i].a, tbl[i].b, ex, 1'b0, i);
    end

    // Second start mid-operation must not disturb the first operands.
    ex.q  = 16'h3E00;
    ex.dz = 1'b0;
    do_op(16'h4200, 16'h4000, ex, 1'b1, 100);
    @(posedge clk); #1;
    chk("no_restart_busy", {31'd0, busy}, 32'd0);

    // Reset asserted mid-operation, just ahead of E6.
    @(negedge clk);
    floatA = 16'h3C00;
    floatB = 16'h3C00;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quotient", {16'd0, quotient}, 32'd0);
    chk("midrst_divZero", {31'd0, divZero}, 32'd0);
    dcount = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("midrst_no_done", dcount, 32'd0);

    ex.q  = 16'h3C00;
    ex.dz = 1'b0;
    do_op(16'h3C00, 16'h3C00, ex, 1'b0, 200);

    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      ex = model(ra, rb);
      do_op(ra, rb, ex, 1'b0, 300 + i);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
